// File: rtl/alu_defs.sv
// Shared encodings for the ALU function select and write-back source select.
// The controller decodes instructions into these same values.
package alu_defs;

   typedef logic [2:0] alu_op_t;

   localparam alu_op_t ALU_ZERO  = 3'd0;
   localparam alu_op_t ALU_ADD   = 3'd1;
   localparam alu_op_t ALU_SUB   = 3'd2;
   localparam alu_op_t ALU_PASSA = 3'd3;
   localparam alu_op_t ALU_XOR   = 3'd4;
   localparam alu_op_t ALU_OR    = 3'd5;
   localparam alu_op_t ALU_AND   = 3'd6;
   localparam alu_op_t ALU_INC   = 3'd7;

   localparam logic WB_ALU = 1'b0;
   localparam logic WB_MEM = 1'b1;

endpackage

// File: rtl/datapath_unit_register_file.sv
// Register file: 2**ADDR_W words, one synchronous write port, two enabled
// combinational read ports. Reads see pre-edge contents, so there is no bypass.
module register_file #(
   parameter int DATA_W = 16,
   parameter int ADDR_W = 4
) (
   input  logic              clock,
   input  logic              clear,
   input  logic [ADDR_W-1:0] w_addr,
   input  logic              w_wr,
   input  logic [DATA_W-1:0] w_data,
   input  logic [ADDR_W-1:0] ra_addr,
   input  logic              ra_rd,
   input  logic [ADDR_W-1:0] rb_addr,
   input  logic              rb_rd,
   output logic [DATA_W-1:0] ra_data,
   output logic [DATA_W-1:0] rb_data
);

   localparam int DEPTH = 2 ** ADDR_W;

   logic [DATA_W-1:0] word_view [DEPTH];

   genvar gi;
   generate
      for (gi = 0; gi < DEPTH; gi++) begin : g_word
         logic [DATA_W-1:0] word_d;
         logic [DATA_W-1:0] word_q;

         // Next value: take the write data only when this word is addressed.
         always_comb begin
            word_d = word_q;
            if (w_wr && (w_addr == ADDR_W'(gi))) begin
               word_d = w_data;
            end
         end

         // Word storage; clear wins over a coincident write.
         always_ff @(posedge clock) begin
            if (clear) begin
               word_q <= '0;
            end else begin
               word_q <= word_d;
            end
         end

         assign word_view[gi] = word_q;
      end
   endgenerate

   assign ra_data = ra_rd ? word_view[ra_addr] : '0;
   assign rb_data = rb_rd ? word_view[rb_addr] : '0;

endmodule

// File: rtl/datapath_unit.sv
// Execution datapath: register file, 8-function ALU, write-back mux and
// registered Z/N/C status flags. Never stalls; every request completes in
// the cycle it is issued.
module datapath_unit
   import alu_defs::*;
#(
   parameter int DATA_W = 16,
   parameter int ADDR_W = 4
) (
   input  logic              clock,
   input  logic              clear,
   input  logic [DATA_W-1:0] d_rdata,
   input  logic              rf_s,
   input  logic [ADDR_W-1:0] rf_w_addr,
   input  logic              rf_w_wr,
   input  logic [ADDR_W-1:0] rf_ra_addr,
   input  logic              rf_ra_rd,
   input  logic [ADDR_W-1:0] rf_rb_addr,
   input  logic              rf_rb_rd,
   input  logic [2:0]        alu_s0,
   output logic [DATA_W-1:0] ra_data,
   output logic [DATA_W-1:0] rb_data,
   output logic [DATA_W-1:0] alu_out,
   output logic [DATA_W-1:0] d_wdata,
   output logic              flag_z,
   output logic              flag_n,
   output logic              flag_c
);

   logic [DATA_W:0]   alu_wide;
   logic              alu_carry;
   logic [DATA_W-1:0] wb_data;
   logic              flag_z_d, flag_n_d, flag_c_d;
   logic              flag_z_q, flag_n_q, flag_c_q;

   register_file #(
      .DATA_W (DATA_W),
      .ADDR_W (ADDR_W)
   ) u_rf (
      .clock   (clock),
      .clear   (clear),
      .w_addr  (rf_w_addr),
      .w_wr    (rf_w_wr),
      .w_data  (wb_data),
      .ra_addr (rf_ra_addr),
      .ra_rd   (rf_ra_rd),
      .rb_addr (rf_rb_addr),
      .rb_rd   (rf_rb_rd),
      .ra_data (ra_data),
      .rb_data (rb_data)
   );

   // ALU evaluated one bit wider so the top bit is the carry (ADD/INC) or
   // borrow (SUB, since the wrapped difference sets it exactly when A<B).
   always_comb begin
      alu_wide = '0;
      unique case (alu_op_t'(alu_s0))
         ALU_ZERO:  alu_wide = '0;
         ALU_ADD:   alu_wide = {1'b0, ra_data} + {1'b0, rb_data};
         ALU_SUB:   alu_wide = {1'b0, ra_data} - {1'b0, rb_data};
         ALU_PASSA: alu_wide = {1'b0, ra_data};
         ALU_XOR:   alu_wide = {1'b0, ra_data ^ rb_data};
         ALU_OR:    alu_wide = {1'b0, ra_data | rb_data};
         ALU_AND:   alu_wide = {1'b0, ra_data & rb_data};
         ALU_INC:   alu_wide = {1'b0, ra_data} + {{DATA_W{1'b0}}, 1'b1};
         default:   alu_wide = '0;
      endcase
   end

   assign alu_out   = alu_wide[DATA_W-1:0];
   assign alu_carry = alu_wide[DATA_W];
   assign wb_data   = (rf_s == WB_MEM) ? d_rdata : alu_out;
   assign d_wdata   = ra_data;

   // Flags capture only on ALU write-backs; loads and idle cycles hold them.
   always_comb begin
      flag_z_d = flag_z_q;
      flag_n_d = flag_n_q;
      flag_c_d = flag_c_q;
      if (rf_w_wr && (rf_s == WB_ALU)) begin
         flag_z_d = (alu_out == '0);
         flag_n_d = alu_out[DATA_W-1];
         flag_c_d = alu_carry;
      end
   end

   // Flag registers with synchronous clear.
   always_ff @(posedge clock) begin
      if (clear) begin
         flag_z_q <= 1'b0;
         flag_n_q <= 1'b0;
         flag_c_q <= 1'b0;
      end else begin
         flag_z_q <= flag_z_d;
         flag_n_q <= flag_n_d;
         flag_c_q <= flag_c_d;
      end
   end

   assign flag_z = flag_z_q;
   assign flag_n = flag_n_q;
   assign flag_c = flag_c_q;

endmodule

// File: doc/datapath_unit.md
Name: datapath_unit

Overview:
- Execution datapath driven by the control unit's rf_*, alu_s0 and rf_s outputs.
- Holds the 16x16 register file, the 8-function ALU and the write-back mux. The mux selects ALU result or data-memory read data.
- Produces the store data for data memory and registered ALU status flags for later branch support.
- Purely slave: it never stalls the control unit; every request completes in the cycle issued.

Parameters:
- DATA_W, 16, datapath and register width
- ADDR_W, 4, register address width; register count = 2**ADDR_W

Ports:
- clock  in  1  system clock, rising-edge
- clear  in  1  synchronous active-high reset
- d_rdata  in  DATA_W  data-memory read data (valid same cycle as d_addr from control unit)
- rf_s  in  1  write-back select: 1 = d_rdata, 0 = ALU result
- rf_w_addr  in  ADDR_W  write address
- rf_w_wr  in  1  write enable
- rf_ra_addr  in  ADDR_W  read port A address
- rf_ra_rd  in  1  read port A enable
- rf_rb_addr  in  ADDR_W  read port B address
- rf_rb_rd  in  1  read port B enable
- alu_s0  in  3  ALU function select
- ra_data  out  DATA_W  port A read data
- rb_data  out  DATA_W  port B read data
- alu_out  out  DATA_W  combinational ALU result
- d_wdata  out  DATA_W  store data to data memory (= ra_data)
- flag_z  out  1  registered zero flag
- flag_n  out  1  registered negative flag (bit DATA_W-1)
- flag_c  out  1  registered carry/borrow flag

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-high (clock port "clock", reset port "clear").
- Reset:
  - clear=1 at a rising edge zeroes all registers and flag_z/n/c.
  - clear overrides any coincident write.
  - Combinational outputs follow zeroed contents from the next cycle.
- Reads:
  - Combinational and asynchronous to the clock.
  - ra_data = rf_ra_rd ? reg[rf_ra_addr] : 0. rb_data likewise with port B.
- Write:
  - At a rising edge with rf_w_wr=1 and clear=0, reg[rf_w_addr] <= wb_data.
  - wb_data = rf_s ? d_rdata : alu_out.
  - All registers, including R0, are writable.
- Read-during-write (same address, same cycle): read returns the OLD value. The new value is visible the cycle after the edge. No bypass.
- Dual read of the same address on both ports is legal; both ports return identical data.
- ALU: combinational on A=ra_data, B=rb_data, computed in DATA_W+1 bits.
  - 0 ZERO: result 0
  - 1 ADD: A+B; carry = bit DATA_W
  - 2 SUB: A-B; carry = 1 on borrow (A<B unsigned)
  - 3 PASSA: A
  - 4 XOR: A^B
  - 5 OR: A|B
  - 6 AND: A&B
  - 7 INC: A+1; carry on wrap from all-ones
  - Results are truncated to DATA_W (wrap-around). Carry is 0 for non-arithmetic ops.
- Flags:
  - Update only on an edge with rf_w_wr=1, rf_s=0 and clear=0.
  - flag_z = (alu_out==0), flag_n = alu_out[DATA_W-1], flag_c as above.
  - Otherwise all three hold, including during memory loads (rf_s=1).
- d_wdata = ra_data at all times. Data memory qualifies it with d_wr from the control unit.
- Latency: register write 1 edge; ALU and read paths 0 cycles.

Decomposition:
- Shared package (alu_defs):
  - ALU opcode constants ALU_ZERO..ALU_INC (3-bit).
  - WB_ALU=0 / WB_MEM=1 select encodings.
  - Also used by controller decoding.
- Sub-module register_file:
  - 2**ADDR_W x DATA_W, one synchronous write port, two enabled combinational read ports, synchronous clear.
- ALU, write-back mux and flag registers live in datapath_unit.

Test Plan:
- Reset:
  - Write 0xBEEF to R5, then clear=1 with a coincident write of 0x1234 to R5.
  - Next cycle read R5 on A -> 0x0000. Flags all 0.
- Load path:
  - d_rdata=0x00A5, rf_s=1, write R3.
  - Read R3 on A and B -> 0x00A5 on both. Flags unchanged from prior values.
- Arithmetic with wrap:
  - R1=0xFFFF, R2=0x0001, alu_s0=1, write R4.
  - R4=0x0000; flag_z=1, flag_c=1, flag_n=0.
  - Then alu_s0=2 with A=R2, B=R1 -> 0x0002, flag_c=1 (borrow).
- Logic ops and disabled ports:
  - R1=0xF0F0, R2=0x0FF0: XOR -> 0xFF00, OR -> 0xFFF0, AND -> 0x00F0, flag_n as expected.
  - rf_rb_rd=0 -> rb_data=0x0000, so AND yields 0x0000.
- Read-during-write:
  - R6=0x1111; same cycle write R6 <= 0x2222 while reading R6 on A.
  - ra_data=0x1111 before the edge, 0x2222 after.
- INC and store data:
  - R7=0x7FFF, alu_s0=7, write R7 -> 0x8000, flag_n=1, flag_c=0.
  - d_wdata tracks ra_data=0x8000 while R7 is on port A.
